load_register_undo: RTL and testbench

Parametrised load register with a bounded undo history. It holds one WIDTH-bit user value (a cell entry in the puzzle datapath) and captures a new value on Load. Each accepted load pushes the previous value into a DEPTH-entry circular history so that Undo can restore earlier entries. It sits between the user-input decode logic and the cell/display logic, and replaces the fixed 7-bit load register where entries must be reversible.

---
 rtl/load_register_undo.sv | 105 ++++++++++
 tb/tb_load_register_undo.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/load_register_undo.sv
// Load register with a bounded circular undo history. Each accepted load pushes the
// previous value so Undo can walk back through up to DEPTH earlier entries.
module load_register_undo #(
  parameter int              WIDTH     = 7,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
  localparam int             CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Load,
  input  logic             Undo,
  input  logic             Clear,
  input  logic [WIDTH-1:0] user_in,
  output logic [WIDTH-1:0] user_out,
  output logic [CW-1:0]    hist_count,
  output logic             hist_empty,
  output logic             hist_full,
  output logic             undo_err
);

  localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   PTR_MAX = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] user_out_d, user_out_q;
  logic [CW-1:0]    count_d, count_q;
  logic [PW-1:0]    wr_ptr_d, wr_ptr_q;
  logic             undo_err_d, undo_err_q;
  logic             hist_empty_q, hist_full_q;
  logic [WIDTH-1:0] hist_d [DEPTH];
  logic [WIDTH-1:0] hist_q [DEPTH];
  logic [PW-1:0]    ptr_prev;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PTR_MAX : p - PW'(1);
  endfunction

  // wr_ptr_q is the next slot to write; once full, that slot also holds the oldest entry
  assign ptr_prev = ptr_dec(wr_ptr_q);

  always_comb begin
    user_out_d = user_out_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    undo_err_d = 1'b0;
    hist_d     = hist_q;
    if (Clear) begin
      user_out_d = RESET_VAL;
      count_d    = '0;
      wr_ptr_d   = '0;
    end else if (Load) begin
      if (user_in != user_out_q) begin
        hist_d[wr_ptr_q] = user_out_q;
        wr_ptr_d         = ptr_inc(wr_ptr_q);
        user_out_d       = user_in;
        if (count_q != CNT_MAX) begin
          count_d = count_q + CW'(1);
        end
      end
    end else if (Undo) begin
      if (count_q == '0) begin
        undo_err_d = 1'b1;
      end else begin
        user_out_d = hist_q[ptr_prev];
        wr_ptr_d   = ptr_prev;
        count_d    = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      user_out_q   <= RESET_VAL;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      undo_err_q   <= 1'b0;
      hist_empty_q <= 1'b1;
      hist_full_q  <= 1'b0;
    end else begin
      user_out_q   <= user_out_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      undo_err_q   <= undo_err_d;
      hist_empty_q <= (count_d == '0);
      hist_full_q  <= (count_d == CNT_MAX);
    end
  end

  // History contents are don't-care after reset, so the storage carries no reset
  always_ff @(posedge clk) begin
    hist_q <= hist_d;
  end

  assign user_out   = user_out_q;
  assign hist_count = count_q;
  assign hist_empty = hist_empty_q;
  assign hist_full  = hist_full_q;
  assign undo_err   = undo_err_q;

endmodule

// File: tb/tb_load_register_undo.sv
// Scoreboard bench for load_register_undo: directed vectors push hand-computed
// expectations; a monitor pops and compares after every clock edge or async reset.
module tb_load_register_undo;

  localparam int WIDTH = 7;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic             Load, Undo, Clear;
  logic [WIDTH-1:0] user_in;
  logic [WIDTH-1:0] user_out;
  logic [CW-1:0]    hist_count;
  logic             hist_empty, hist_full, undo_err;

  typedef struct {
    logic [WIDTH-1:0] out;
    int               cnt;
    logic             err;
    string            tag;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;
  event asyncChk;

  load_register_undo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .Load(Load), .Undo(Undo), .Clear(Clear),
    .user_in(user_in), .user_out(user_out), .hist_count(hist_count),
    .hist_empty(hist_empty), .hist_full(hist_full), .undo_err(undo_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expectations are pushed in issue order and popped one per observation point
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or asyncChk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.tag, ".user_out"},   32'(user_out),   32'(e.out));
        checkOutput({e.tag, ".hist_count"}, 32'(hist_count), 32'(e.cnt));
        checkOutput({e.tag, ".hist_empty"}, 32'(hist_empty), 32'(e.cnt == 0));
        checkOutput({e.tag, ".hist_full"},  32'(hist_full),  32'(e.cnt == DEPTH));
        checkOutput({e.tag, ".undo_err"},   32'(undo_err),   32'(e.err));
      end
    end
  end

  task automatic pushExp(input string tag, input logic [WIDTH-1:0] o, input int c, input logic err);
    exp_t e;
    e.out = o; e.cnt = c; e.err = err; e.tag = tag;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input string tag, input logic ld, input logic ud, input logic clr,
                               input logic [WIDTH-1:0] din,
                               input logic [WIDTH-1:0] expOut, input int expCnt, input logic expErr);
    @(negedge clk);
    Load = ld; Undo = ud; Clear = clr; user_in = din;
    pushExp(tag, expOut, expCnt, expErr);
  endtask

  task automatic asyncResetCheck(input string tag);
    @(negedge clk);
    Load = 0; Undo = 0; Clear = 0; user_in = '0;
    #2 reset = 1'b0;
    #1 pushExp(tag, 7'h7F, 0, 1'b0);
    -> asyncChk;
    #2;
  endtask

  initial begin
    reset = 1'b0; Load = 0; Undo = 0; Clear = 0; user_in = '0;
    repeat (2) @(negedge clk);
    #1 pushExp("rst", 7'h7F, 0, 1'b0);
    -> asyncChk;
    @(negedge clk);
    reset = 1'b1;

    applyStimulus("undoEmpty",  0, 1, 0, 7'h00, 7'h7F, 0, 1);
    applyStimulus("errPulse",   0, 0, 0, 7'h00, 7'h7F, 0, 0);

    applyStimulus("ld01",       1, 0, 0, 7'h01, 7'h01, 1, 0);
    applyStimulus("ld02",       1, 0, 0, 7'h02, 7'h02, 2, 0);
    applyStimulus("ld03",       1, 0, 0, 7'h03, 7'h03, 3, 0);
    applyStimulus("undo1",      0, 1, 0, 7'h00, 7'h02, 2, 0);
    applyStimulus("undo2",      0, 1, 0, 7'h00, 7'h01, 1, 0);
    applyStimulus("undo3",      0, 1, 0, 7'h00, 7'h7F, 0, 0);

    for (int i = 1; i <= 6; i++)
      applyStimulus($sformatf("ovf%0d", i), 1, 0, 0, 7'(i), 7'(i), (i < DEPTH) ? i : DEPTH, 0);
    applyStimulus("wrapUndo1",  0, 1, 0, 7'h00, 7'h05, 3, 0);
    applyStimulus("wrapUndo2",  0, 1, 0, 7'h00, 7'h04, 2, 0);
    applyStimulus("wrapUndo3",  0, 1, 0, 7'h00, 7'h03, 1, 0);
    applyStimulus("wrapUndo4",  0, 1, 0, 7'h00, 7'h02, 0, 0);
    applyStimulus("wrapUndo5",  0, 1, 0, 7'h00, 7'h02, 0, 1);

    applyStimulus("ld05",       1, 0, 0, 7'h05, 7'h05, 1, 0);
    applyStimulus("dupLd05",    1, 0, 0, 7'h05, 7'h05, 1, 0);
    applyStimulus("undoDup",    0, 1, 0, 7'h00, 7'h02, 0, 0);

    applyStimulus("ldUndo09",   1, 1, 0, 7'h09, 7'h09, 1, 0);
    applyStimulus("clrLd0A",    1, 0, 1, 7'h0A, 7'h7F, 0, 0);
    applyStimulus("undoAfterClr", 0, 1, 0, 7'h00, 7'h7F, 0, 1);

    applyStimulus("ld11",       1, 0, 0, 7'h11, 7'h11, 1, 0);
    applyStimulus("ld12",       1, 0, 0, 7'h12, 7'h12, 2, 0);
    applyStimulus("ld13",       1, 0, 0, 7'h13, 7'h13, 3, 0);
    asyncResetCheck("midRst");
    @(negedge clk);
    reset = 1'b1;
    applyStimulus("undoPostRst", 0, 1, 0, 7'h00, 7'h7F, 0, 1);
    applyStimulus("holdPostRst", 0, 0, 0, 7'h00, 7'h7F, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
